// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared types for the register-file writeback path
package rf_wb_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        reg_idx_t rd;
        word_t    data;
    } wb_entry_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

endpackage

// File: rtl/rf_wb_queue.sv
// rtl/rf_wb_queue.sv - writeback FIFO with age-ordered view for scoreboard search
module rf_wb_queue
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         ord_valid,
    output wb_entry_t                ord_entry [DEPTH]
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Entry storage; stale slots are masked by ord_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // Index 0 is the oldest entry (the head), index count-1 the youngest
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ord_entry[i] = mem[rd_ptr + AW'(i)];
            ord_valid[i] = ((AW+1)'(i) < count);
        end
    end

endmodule

// File: rtl/rf_write_sequencer.sv
// rtl/rf_write_sequencer.sv - arbitrates ALU/long writebacks into a queue and issues RF writes
module rf_write_sequencer
    import rf_wb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_reg,
    input  logic [31:0]              alu_data,
    input  logic                     lng_valid,
    output logic                     lng_ready,
    input  logic [4:0]               lng_reg,
    input  logic [31:0]              lng_data,
    input  logic                     rd_req,
    output logic                     rd_grant,
    input  logic [4:0]               read_register1,
    input  logic [4:0]               read_register2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [31:0]              byp_data1,
    output logic [31:0]              byp_data2,
    output logic                     RegWrite,
    output logic [4:0]               write_register,
    output logic [31:0]              write_data_register,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t        head;
    wb_entry_t        push_entry;
    wb_entry_t        ord_entry [DEPTH];
    logic [DEPTH-1:0] ord_valid;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             space;
    logic             starve;
    logic [SW-1:0]    starve_cnt;

    // A full queue must drain, so it overrides a pending decode read
    assign pop      = !empty && !(rd_req && !full);
    assign space    = !full || pop;
    assign starve   = (starve_cnt >= SW'(STARVE_LIMIT));
    assign rd_grant = rd_req && !pop;

    assign alu_ready = alu_valid && space && !(starve && lng_valid);
    assign lng_ready = lng_valid && space && (!alu_valid || starve);

    // Writes to r0 complete the handshake but are discarded
    assign push       = (alu_ready && (alu_reg != ZERO_REG)) || (lng_ready && (lng_reg != ZERO_REG));
    assign push_entry = lng_ready ? wb_entry_t'{rd: lng_reg, data: lng_data}
                                  : wb_entry_t'{rd: alu_reg, data: alu_data};

    assign RegWrite            = pop;
    assign write_register      = pop ? head.rd   : ZERO_REG;
    assign write_data_register = pop ? head.data : '0;

    rf_wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .empty      (empty),
        .full       (full),
        .count      (occupancy),
        .ord_valid  (ord_valid),
        .ord_entry  (ord_entry)
    );

    // Count consecutive refused long-path cycles, saturating at the limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!lng_valid || lng_ready) begin
            starve_cnt <= '0;
        end else if (!starve) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Scoreboard: scan oldest to youngest so the last match wins the bypass data
    always_comb begin
        hit1      = 1'b0;
        hit2      = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ord_valid[i] && (read_register1 != ZERO_REG) && (ord_entry[i].rd == read_register1)) begin
                hit1      = 1'b1;
                byp_data1 = ord_entry[i].data;
            end
            if (ord_valid[i] && (read_register2 != ZERO_REG) && (ord_entry[i].rd == read_register2)) begin
                hit2      = 1'b1;
                byp_data2 = ord_entry[i].data;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_sequencer.sv
// tb/tb_rf_write_sequencer.sv - randomized and directed checks against a queue-based model
module tb_rf_write_sequencer;

    localparam int DEPTH = 4;
    localparam int LIM   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, lng_valid, rd_req;
    logic        alu_ready, lng_ready, rd_grant;
    logic [4:0]  alu_reg, lng_reg, read_register1, read_register2;
    logic [31:0] alu_data, lng_data;
    logic        hit1, hit2, RegWrite;
    logic [31:0] byp_data1, byp_data2, write_data_register;
    logic [4:0]  write_register;
    logic [2:0]  occupancy;

    rf_write_sequencer #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .alu_valid           (alu_valid),
        .alu_ready           (alu_ready),
        .alu_reg             (alu_reg),
        .alu_data            (alu_data),
        .lng_valid           (lng_valid),
        .lng_ready           (lng_ready),
        .lng_reg             (lng_reg),
        .lng_data            (lng_data),
        .rd_req              (rd_req),
        .rd_grant            (rd_grant),
        .read_register1      (read_register1),
        .read_register2      (read_register2),
        .hit1                (hit1),
        .hit2                (hit2),
        .byp_data1           (byp_data1),
        .byp_data2           (byp_data2),
        .RegWrite            (RegWrite),
        .write_register      (write_register),
        .write_data_register (write_data_register),
        .occupancy           (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    int   refused;
    int   n_cmp;
    int   n_bad;
    bit   e_pop, e_ar, e_lr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit lookup(input logic [4:0] src, output logic [31:0] d);
        d = '0;
        if (src == 5'd0) return 1'b0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].r == src) begin
                d = mq[i].d;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic check_model();
        bit          full, space, starve, h1, h2;
        logic [31:0] d1, d2;
        full   = (mq.size() == DEPTH);
        e_pop  = (mq.size() != 0) && !(rd_req && !full);
        space  = !full || e_pop;
        starve = (refused >= LIM);
        e_lr   = lng_valid && space && (!alu_valid || starve);
        e_ar   = alu_valid && space && !(starve && lng_valid);
        h1 = lookup(read_register1, d1);
        h2 = lookup(read_register2, d2);
        check("alu_ready", alu_ready, e_ar);
        check("lng_ready", lng_ready, e_lr);
        check("RegWrite", RegWrite, e_pop);
        check("rd_grant", rd_grant, rd_req && !e_pop);
        check("write_register", write_register, e_pop ? mq[0].r : 5'd0);
        check("write_data", write_data_register, e_pop ? mq[0].d : 32'd0);
        check("hit1", hit1, h1);
        check("hit2", hit2, h2);
        check("byp_data1", byp_data1, d1);
        check("byp_data2", byp_data2, d2);
        check("occupancy", occupancy, mq.size());
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            refused = 0;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (e_ar && alu_reg != 5'd0) mq.push_back('{alu_reg, alu_data});
            if (e_lr && lng_reg != 5'd0) mq.push_back('{lng_reg, lng_data});
            refused = (lng_valid && !e_lr) ? refused + 1 : 0;
        end
        #1;
    endtask

    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                        input logic rq, input logic [4:0] s1, input logic [4:0] s2);
        alu_valid = av; alu_reg = ar; alu_data = ad;
        lng_valid = lv; lng_reg = lr; lng_data = ld;
        rd_req = rq; read_register1 = s1; read_register2 = s2;
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input logic rq, input logic [4:0] s1);
        step(0, 0, 0, 0, 0, 0, rq, s1, 0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; refused = 0;
        rst_n = 1'b0;
        alu_valid = 0; alu_reg = 0; alu_data = 0;
        lng_valid = 0; lng_reg = 0; lng_data = 0;
        rd_req = 0; read_register1 = 0; read_register2 = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // reset state
        idle(0, 5);
        check("rst_occupancy", occupancy, 0);
        check("rst_regwrite", RegWrite, 0);
        advance();

        // single ALU write, visible next cycle
        step(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0);
        check("t1_alu_ready", alu_ready, 1);
        advance();
        idle(0, 0);
        check("t1_regwrite", RegWrite, 1);
        check("t1_wreg", write_register, 5);
        check("t1_wdata", write_data_register, 32'h1234);
        advance();

        // contention with reads held: queue fills, long path wins after starving
        for (int k = 0; k < 5; k++) begin
            step(1, 5'(1 + k), 32'hA0 + k, 1, 9, 32'hC0 + k, 1, 9, 0);
            if (k == 3) check("t2_lng_starve_win", lng_ready, 1);
            if (k == 4) begin
                check("t2_forced_write", RegWrite, 1);
                check("t2_rd_denied", rd_grant, 0);
                check("t2_full", occupancy, 4);
            end
            advance();
        end
        for (int k = 0; k < 6; k++) begin idle(0, 0); advance(); end

        // youngest-match bypass and in-order writes
        step(1, 7, 32'hA, 0, 0, 0, 1, 0, 0); advance();
        step(1, 7, 32'hB, 0, 0, 0, 1, 0, 0); advance();
        idle(1, 7);
        check("t3_hit1", hit1, 1);
        check("t3_byp1", byp_data1, 32'hB);
        advance();
        idle(0, 0); check("t3_first", write_data_register, 32'hA); advance();
        idle(0, 0); check("t3_second", write_data_register, 32'hB); advance();

        // r0 write is acknowledged and dropped
        step(1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0);
        check("t4_ready", alu_ready, 1);
        advance();
        idle(0, 0);
        check("t4_occ", occupancy, 0);
        check("t4_nowrite", RegWrite, 0);
        check("t4_hit0", hit1, 0);
        advance();

        // full queue: push and pop in the same cycle, pointer wrap
        for (int k = 0; k < 10; k++) begin
            step(1, 5'(10 + k), 32'h500 + k, 0, 0, 0, 1, 0, 0);
            if (k >= 4) begin
                check("t5_accept_full", alu_ready, 1);
                check("t5_occ_full", occupancy, 4);
            end
            advance();
        end
        for (int k = 0; k < 5; k++) begin idle(0, 0); advance(); end

        // reset drops queued entries
        for (int k = 0; k < 3; k++) begin step(1, 5'(20 + k), k, 0, 0, 0, 1, 0, 0); advance(); end
        rst_n = 1'b0;
        idle(1, 20);
        advance();
        rst_n = 1'b1;
        idle(0, 20);
        check("t6_occ", occupancy, 0);
        check("t6_regwrite", RegWrite, 0);
        check("t6_hit1", hit1, 0);
        advance();

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
